// File: rtl/chiptune_synth_pkg.sv
// Shared types and constants for the multi-voice chiptune synthesiser.
package chiptune_synth_pkg;

    typedef enum logic [1:0] {
        SQUARE  = 2'd0,
        PULSE25 = 2'd1,
        NOISE   = 2'd2,
        OFF     = 2'd3
    } wave_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        MIX   = 2'd2
    } state_t;

    localparam int LFSR_W = 15;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h0001;
    localparam int LFSR_TAP_HI = 14;
    localparam int LFSR_TAP_LO = 13;

    // Fibonacci form of x^15 + x^14 + 1, feedback enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/chiptune_synth_dac.sv
// First-order sigma-delta: carry of a W-bit accumulator is the output bit, one cycle behind in.
// Free-running every clock, no flow control; mean duty = in / 2^W.
module sigma_delta_dac #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in,
    output logic         out
);
    logic [W-1:0] acc;
    logic [W:0]   total;

    assign total = {1'b0, acc} + {1'b0, in};

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            out <= 1'b0;
        end else begin
            acc <= total[W-1:0];
            out <= total[W];
        end
    end
endmodule

// File: rtl/chiptune_synth.sv
// NCH time-multiplexed voices swept once per sample_tick through one shared datapath; mix_out updates NCH+2 cycles after the tick.
// cmd_ready drops from tick until the sweep's MIX cycle completes; a tick while one is pending sets sticky overrun.
module chiptune_synth
    import chiptune_synth_pkg::*;
#(
    parameter  int NCH     = 4,
    parameter  int PHASE_W = 16,
    parameter  int INC_W   = 8,
    parameter  int VOL_W   = 6,
    localparam int MIX_W   = VOL_W + $clog2(NCH + 1),
    localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_tick,
    input  logic             frame_tick,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CH_W-1:0]  cmd_chan,
    input  logic [INC_W-1:0] cmd_inc,
    input  logic [1:0]       cmd_oct,
    input  logic [1:0]       cmd_wave,
    input  logic [2:0]       cmd_decay,
    input  logic             cmd_trig,
    output logic [MIX_W-1:0] mix_out,
    output logic             pwm_out,
    output logic             busy,
    output logic             overrun
);
    localparam int PIDX_W = $clog2(PHASE_W);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NCH - 1);

    state_t state, state_nxt;
    logic [CH_W-1:0]   ch;
    logic [MIX_W-1:0]  sum;
    logic              sample_pending, frame_pending;
    logic [LFSR_W-1:0] lfsr;

    logic [PHASE_W-1:0] phase_q [NCH];
    logic [INC_W-1:0]   inc_q   [NCH];
    logic [1:0]         oct_q   [NCH];
    wave_t              wave_q  [NCH];
    logic [2:0]         decay_q [NCH];
    logic [VOL_W-1:0]   vol_q   [NCH];
    logic               noise_q [NCH];
    logic               prev_q  [NCH];

    logic [PHASE_W-1:0] phase_nxt;
    logic [PIDX_W-1:0]  bit_idx, pulse_idx;
    logic               sel_bit, pulse_bit, noise_nxt, voice_on;
    logic [VOL_W-1:0]   vol_nxt;
    logic               cmd_accept, chan_ok;

    assign cmd_accept = cmd_valid & cmd_ready;
    assign chan_ok    = 32'(cmd_chan) < NCH;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sample_pending) state_nxt = SWEEP;
            SWEEP:   if (ch == CH_LAST) state_nxt = MIX;
            MIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        cmd_ready = (state == IDLE) & ~sample_pending;
    end

    // The one voice datapath, fed by whichever voice ch selects.
    always_comb begin
        phase_nxt = phase_q[ch] + PHASE_W'(inc_q[ch]);
        bit_idx   = PIDX_W'(PHASE_W - 1) - PIDX_W'(oct_q[ch]);
        pulse_idx = bit_idx - PIDX_W'(1);
        sel_bit   = phase_nxt[bit_idx];
        pulse_bit = phase_nxt[pulse_idx];
        noise_nxt = (sel_bit & ~prev_q[ch]) ? lfsr[0] : noise_q[ch];
        case (wave_q[ch])
            SQUARE:  voice_on = sel_bit;
            PULSE25: voice_on = sel_bit & pulse_bit;
            NOISE:   voice_on = noise_nxt;
            default: voice_on = 1'b0;
        endcase
        vol_nxt = vol_q[ch];
        if (frame_pending && decay_q[ch] != 3'd0)
            vol_nxt = vol_q[ch] - (vol_q[ch] >> decay_q[ch]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch             <= '0;
            sum            <= '0;
            mix_out        <= '0;
            sample_pending <= 1'b0;
            frame_pending  <= 1'b0;
            overrun        <= 1'b0;
            lfsr           <= LFSR_SEED;
            for (int i = 0; i < NCH; i++) begin
                phase_q[i] <= '0;
                inc_q[i]   <= '0;
                oct_q[i]   <= '0;
                wave_q[i]  <= SQUARE;
                decay_q[i] <= '0;
                vol_q[i]   <= '0;
                noise_q[i] <= 1'b0;
                prev_q[i]  <= 1'b0;
            end
        end else begin
            lfsr <= lfsr_next(lfsr);

            if (state == IDLE && sample_pending) begin
                ch  <= '0;
                sum <= '0;
            end

            // Sample is taken with the pre-decay volume.
            if (state == SWEEP) begin
                phase_q[ch] <= phase_nxt;
                prev_q[ch]  <= sel_bit;
                noise_q[ch] <= noise_nxt;
                vol_q[ch]   <= vol_nxt;
                sum         <= sum + (voice_on ? MIX_W'(vol_q[ch]) : '0);
                if (ch != CH_LAST) ch <= ch + CH_W'(1);
            end

            if (state == MIX) mix_out <= sum;

            if (cmd_accept && chan_ok) begin
                inc_q[cmd_chan]   <= cmd_inc;
                oct_q[cmd_chan]   <= cmd_oct;
                wave_q[cmd_chan]  <= wave_t'(cmd_wave);
                decay_q[cmd_chan] <= cmd_decay;
                if (cmd_trig) begin
                    vol_q[cmd_chan]   <= '1;
                    phase_q[cmd_chan] <= '0;
                    prev_q[cmd_chan]  <= 1'b0;
                end
            end

            // A new tick arriving on the MIX cycle must not be lost, so set beats clear.
            if (sample_tick)       sample_pending <= 1'b1;
            else if (state == MIX) sample_pending <= 1'b0;

            if (frame_tick)        frame_pending <= 1'b1;
            else if (state == MIX) frame_pending <= 1'b0;

            if (sample_tick && sample_pending) overrun <= 1'b1;
        end
    end

    sigma_delta_dac #(.W(MIX_W)) u_dac (
        .clk   (clk),
        .reset (reset),
        .in    (mix_out),
        .out   (pwm_out)
    );
endmodule
